// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - strobe-driven circular sample capture with pre/post trigger windows
module capture_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              sampleEn,
    input  logic              trigger,
    input  logic [DATA_W-1:0] probe,
    input  logic [ADDR_W:0]   preCount,
    input  logic [ADDR_W:0]   postCount,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memData,
    output logic [ADDR_W-1:0] trigAddr,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [CW-1:0]     pre_cnt, post_cnt;
    logic [CW-1:0]     pre_lat, post_lat;
    logic [CW-1:0]     pre_clamp;
    logic              capturing;
    logic              start;
    logic              wr_fire;
    logic              trig_hit;

    always_comb begin
        pre_clamp  = (preCount > DEPTH) ? DEPTH : preCount;
        capturing  = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
        start      = arm && !abort && ((state == S_IDLE) || (state == S_DONE));
        wr_fire    = capturing && sampleEn && !abort;
        trig_hit   = wr_fire && (state == S_ARMED) && trigger;
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // An empty pre-window skips PRE so the very next strobe may trigger.
                    if (arm) state_next = (pre_clamp == '0) ? S_ARMED : S_PRE;
                end
                S_PRE: begin
                    if (sampleEn && (pre_cnt + CW'(1) == pre_lat)) state_next = S_ARMED;
                end
                S_ARMED: begin
                    if (sampleEn && trigger) state_next = (post_lat == '0) ? S_DONE : S_POST;
                end
                S_POST: begin
                    if (sampleEn && (post_cnt + CW'(1) == post_lat)) state_next = S_DONE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            pre_lat  <= '0;
            post_lat <= '0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memData  <= '0;
            trigAddr <= '0;
            wrapped  <= 1'b0;
        end else begin
            state <= state_next;
            memWe <= wr_fire;
            if (wr_fire) begin
                memAddr <= ptr;
                memData <= probe;
                ptr     <= ptr + ADDR_W'(1);
                if (ptr == '1) wrapped <= 1'b1;
                if (state == S_PRE)  pre_cnt  <= pre_cnt + CW'(1);
                if (state == S_POST) post_cnt <= post_cnt + CW'(1);
            end
            if (trig_hit) trigAddr <= ptr;
            if (start) begin
                ptr      <= '0;
                pre_cnt  <= '0;
                post_cnt <= '0;
                wrapped  <= 1'b0;
                pre_lat  <= pre_clamp;
                post_lat <= postCount;
            end
            if (abort) wrapped <= 1'b0;
        end
    end

    assign busy = capturing;
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - directed self-checking bench for capture_sequencer (ADDR_W=3)
module tb_capture_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              sampleEn = 1'b0;
    logic              trigger = 1'b0;
    logic [DATA_W-1:0] probe = '0;
    logic [ADDR_W:0]   preCount = '0;
    logic [ADDR_W:0]   postCount = '0;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic [ADDR_W-1:0] trigAddr;
    logic              busy;
    logic              done;
    logic              wrapped;

    int n_checks = 0;
    int n_pass = 0;

    capture_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .sampleEn(sampleEn), .trigger(trigger), .probe(probe),
        .preCount(preCount), .postCount(postCount),
        .memWe(memWe), .memAddr(memAddr), .memData(memData),
        .trigAddr(trigAddr), .busy(busy), .done(done), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_cap(input logic [ADDR_W:0] pre, input logic [ADDR_W:0] post);
        preCount  = pre;
        postCount = post;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic strobe(input logic [DATA_W-1:0] d, input logic t);
        sampleEn = 1'b1;
        trigger  = t;
        probe    = d;
        tick();
        sampleEn = 1'b0;
        trigger  = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input int addr, input logic [DATA_W-1:0] d);
        check({tag, "_we"}, 32'(memWe), 32'd1);
        check({tag, "_addr"}, 32'(memAddr), 32'(addr));
        check({tag, "_data"}, 32'(memData), 32'(d));
    endtask

    initial begin
        tick();
        tick();
        check("rst_we", 32'(memWe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wrapped", 32'(wrapped), 0);
        check("rst_addr", 32'(memAddr), 0);
        check("rst_data", 32'(memData), 0);
        check("rst_trig", 32'(trigAddr), 0);
        reset = 1'b0;
        tick();

        // pre=0, post=3, trigger on first strobe
        arm_cap(4'd0, 4'd3);
        check("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            strobe(8'hA0 + 8'(i), i == 0);
            chk_wr($sformatf("t1_w%0d", i), i, 8'hA0 + 8'(i));
            check($sformatf("t1_done%0d", i), 32'(done), (i == 3) ? 1 : 0);
            check($sformatf("t1_busy%0d", i), 32'(busy), (i == 3) ? 0 : 1);
        end
        check("t1_trig", 32'(trigAddr), 0);
        strobe(8'h55, 1'b0);
        check("t1_nowr_after_done", 32'(memWe), 0);

        // pre=4 with trigger held high from arm
        arm_cap(4'd4, 4'd1);
        for (int i = 0; i < 4; i++) begin
            strobe(8'h10 + 8'(i), 1'b1);
            chk_wr($sformatf("t2_w%0d", i), i, 8'h10 + 8'(i));
        end
        check("t2_trig_ignored", 32'(trigAddr), 0);
        check("t2_not_done", 32'(done), 0);
        strobe(8'h14, 1'b1);
        chk_wr("t2_trigwr", 4, 8'h14);
        check("t2_trig", 32'(trigAddr), 4);
        strobe(8'h15, 1'b0);
        chk_wr("t2_post", 5, 8'h15);
        check("t2_done", 32'(done), 1);

        // preCount 15 clamps to depth 8
        arm_cap(4'd15, 4'd0);
        for (int i = 0; i < 8; i++) strobe(8'h20 + 8'(i), 1'b1);
        check("clamp_trig_ignored", 32'(trigAddr), 4);
        check("clamp_busy", 32'(busy), 1);
        strobe(8'h28, 1'b1);
        chk_wr("clamp_trigwr", 0, 8'h28);
        check("clamp_trig", 32'(trigAddr), 0);
        check("clamp_done", 32'(done), 1);

        // wrap: pre=2, post=2, trigger on strobe 11
        arm_cap(4'd2, 4'd2);
        check("t3_wrapped_cleared", 32'(wrapped), 0);
        for (int k = 1; k <= 13; k++) begin
            strobe(8'h30 + 8'(k), k == 11);
            chk_wr($sformatf("t3_s%0d", k), (k - 1) % 8, 8'h30 + 8'(k));
            if (k == 7) check("t3_wrap_pre", 32'(wrapped), 0);
            if (k == 8) check("t3_wrap_set", 32'(wrapped), 1);
            if (k == 12) check("t3_not_done", 32'(done), 0);
        end
        check("t3_trig", 32'(trigAddr), 2);
        check("t3_wrapped", 32'(wrapped), 1);
        check("t3_done", 32'(done), 1);
        strobe(8'hEE, 1'b0);
        check("t3_nowr1", 32'(memWe), 0);
        strobe(8'hEF, 1'b1);
        check("t3_nowr2", 32'(memWe), 0);

        // trigger without sampleEn ignored; post=0 finishes on trigger write
        arm_cap(4'd0, 4'd0);
        check("t4_wrapped_cleared", 32'(wrapped), 0);
        for (int i = 0; i < 3; i++) begin
            trigger = 1'b1;
            tick();
            trigger = 1'b0;
            tick();
        end
        check("t4_nowr", 32'(memWe), 0);
        check("t4_still_busy", 32'(busy), 1);
        check("t4_trig_unchanged", 32'(trigAddr), 2);
        strobe(8'h77, 1'b1);
        chk_wr("t4_trigwr", 0, 8'h77);
        check("t4_trig", 32'(trigAddr), 0);
        check("t4_done", 32'(done), 1);
        strobe(8'h78, 1'b0);
        check("t4_single_write", 32'(memWe), 0);

        // abort in POST beats sampleEn and arm, clears wrapped
        arm_cap(4'd0, 4'd10);
        strobe(8'h40, 1'b1);
        for (int i = 1; i <= 8; i++) strobe(8'h40 + 8'(i), 1'b0);
        check("t5_addr_wrapped", 32'(memAddr), 0);
        check("t5_wrapped", 32'(wrapped), 1);
        check("t5_busy", 32'(busy), 1);
        abort = 1'b1;
        arm = 1'b1;
        sampleEn = 1'b1;
        probe = 8'h99;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        sampleEn = 1'b0;
        check("t5_abort_we", 32'(memWe), 0);
        check("t5_abort_busy", 32'(busy), 0);
        check("t5_abort_done", 32'(done), 0);
        check("t5_abort_wrapped", 32'(wrapped), 0);
        arm_cap(4'd0, 4'd1);
        check("t5_rearm_busy", 32'(busy), 1);
        strobe(8'h50, 1'b1);
        chk_wr("t5_restart", 0, 8'h50);
        strobe(8'h51, 1'b0);
        check("t5_done", 32'(done), 1);

        // arm while ARMED does not restart
        arm_cap(4'd0, 4'd1);
        strobe(8'h60, 1'b0);
        strobe(8'h61, 1'b0);
        arm_cap(4'd0, 4'd0);
        strobe(8'h62, 1'b0);
        chk_wr("t6_continue", 2, 8'h62);
        strobe(8'h63, 1'b1);
        chk_wr("t6_trigwr", 3, 8'h63);
        check("t6_trig", 32'(trigAddr), 3);
        check("t6_in_post", 32'(busy), 1);

        // reset mid-POST with a strobe present
        reset = 1'b1;
        sampleEn = 1'b1;
        probe = 8'hAB;
        tick();
        reset = 1'b0;
        sampleEn = 1'b0;
        check("t7_we", 32'(memWe), 0);
        check("t7_addr", 32'(memAddr), 0);
        check("t7_data", 32'(memData), 0);
        check("t7_trig", 32'(trigAddr), 0);
        check("t7_busy", 32'(busy), 0);
        check("t7_done", 32'(done), 0);
        check("t7_wrapped", 32'(wrapped), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
